// File: rtl/alu_op_sequencer.sv
// Single-owner sequencer for the TotalALU datapath: one op in flight, multi-cycle timing hidden.
// Optional feature: define ALU_SEQ_ILLEGAL_EN to reject unknown funct codes with rsp_err.
module alu_op_sequencer #(
  parameter int unsigned RES_LAT    = 1,
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned HILO_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        busy
);

  localparam logic [5:0] FnMultu = 6'd25;
  localparam logic [5:0] FnDivu  = 6'd27;

  localparam logic [5:0] ResLoad  = 6'(RES_LAT - 1);
  localparam logic [5:0] MulLoad  = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] HiloLoad = 6'(HILO_LAT - 1);

  typedef enum logic [2:0] {StIdle, StShort, StLong, StSettle, StResp} state_e;

`ifdef ALU_SEQ_ILLEGAL_EN
  function automatic logic fn_legal(input logic [5:0] fn);
    case (fn)
      6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd27, 6'd16, 6'd18: fn_legal = 1'b1;
      default: fn_legal = 1'b0;
    endcase
  endfunction
`endif

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  funct_q, funct_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        short_q, short_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic [5:0]  alu_signal_q, alu_signal_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct_d     = funct_q;
    a_d         = a_q;
    b_d         = b_q;
    short_d     = short_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    // Outputs are registered from the current state, so the datapath sees each phase one
    // cycle after the FSM enters it; result sampling lines up with the last driven cycle.
    alu_signal_d = (state_q == StShort || state_q == StLong) ? funct_q : 6'd0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          funct_d = req_funct;
          a_d     = req_a;
          b_d     = req_b;
          err_d   = 1'b0;
          if (req_funct == FnMultu || req_funct == FnDivu) begin
            state_d = StLong;
            cnt_d   = MulLoad;
            short_d = 1'b0;
          end else begin
            state_d = StShort;
            cnt_d   = ResLoad;
            short_d = 1'b1;
          end
`ifdef ALU_SEQ_ILLEGAL_EN
          if (!fn_legal(req_funct)) begin
            state_d = StResp;
            cnt_d   = 6'd0;
            short_d = 1'b0;
            err_d   = 1'b1;
          end
`endif
        end
      end
      StShort: begin
        if (cnt_q == 6'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 6'd1;
      end
      StLong: begin
        if (cnt_q == 6'd0) begin
          state_d = StSettle;
          cnt_d   = HiloLoad;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StSettle: begin
        if (cnt_q == 6'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 6'd1;
      end
      StResp: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = short_q ? alu_result : 32'd0;
          rsp_err_d   = err_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 6'd0;
      funct_q      <= 6'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      short_q      <= 1'b0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_err_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      alu_signal_q <= 6'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct_q      <= funct_d;
      a_q          <= a_d;
      b_q          <= b_d;
      short_q      <= short_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      alu_signal_q <= alu_signal_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign alu_signal = alu_signal_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural TotalALU datapath model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_funct = 6'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [5:0]  alu_signal;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        busy;

  alu_op_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct  (req_funct),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_signal (alu_signal),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Datapath model: combinational ops, HiLo written after 32 held cycles of MULTU/DIVU.
  logic [31:0] hi = 32'd0;
  logic [31:0] lo = 32'd0;
  int          mcnt = 0;

  always_comb begin
    alu_result = 32'd0;
    case (alu_signal)
      6'd36:        alu_result = alu_a & alu_b;
      6'd37:        alu_result = alu_a | alu_b;
      6'd32:        alu_result = alu_a + alu_b;
      6'd34:        alu_result = alu_a - alu_b;
      6'd42:        alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'd2:         alu_result = alu_a >> alu_b[4:0];
      6'd16:        alu_result = hi;
      6'd18:        alu_result = lo;
      6'd0, 6'd25, 6'd27: alu_result = 32'd0;
      default:      alu_result = 32'hDEAD0000 | {26'd0, alu_signal};
    endcase
  end

  always @(negedge clk) begin
    if (alu_signal == 6'd25 || alu_signal == 6'd27) begin
      if (mcnt == 31) begin
        if (alu_signal == 6'd25) {hi, lo} <= 64'(alu_a) * 64'(alu_b);
        else begin
          lo <= alu_a / alu_b;
          hi <= alu_a % alu_b;
        end
        mcnt <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Event monitors, sampled mid-cycle.
  int         cyc = 0;
  int         sig_cnt = 0;
  int         acc_cnt = 0;
  int         rsp_cnt = 0;
  logic [5:0] watch_fn = 6'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (alu_signal == watch_fn) sig_cnt <= sig_cnt + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int last_acc_cyc = 0;
  int last_hs_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, " ready timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat,
                        input logic exp_err, input int exp_sig, input int hold);
    bit ok;
    int lat;
    int sig0;
    int acc0;
    wait_ready(tag, ok);
    if (!ok) return;
    watch_fn  = fn;
    req_valid = 1'b1;
    req_funct = fn;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    last_acc_cyc = cyc;
    sig0         = sig_cnt;
    lat          = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (lat < 0) return;
    check({tag, " data"}, rsp_data, exp_data);
    check({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check({tag, " ready during rsp"}, {31'd0, req_ready}, 32'd0);
    acc0 = acc_cnt;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_funct = 6'd32;
      @(posedge clk);
      #1;
      check({tag, " held valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, " held data"}, rsp_data, exp_data);
    end
    req_valid = 1'b0;
    if (hold > 0) begin
      check({tag, " no accept in hold"}, 32'(acc_cnt - acc0), 32'd0);
      check({tag, " signal idle in hold"}, {26'd0, alu_signal}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready   = 1'b0;
    last_hs_cyc = cyc;
    check({tag, " valid drops"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " ready after hs"}, {31'd0, req_ready}, 32'd1);
    check({tag, " signal cycles"}, 32'(sig_cnt - sig0), 32'(exp_sig));
  endtask

  initial begin
    bit ok;
    int r0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst alu_signal", {26'd0, alu_signal}, 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    run_op("add", 6'd32, 32'd5, 32'd7, 32'd12, 2, 1'b0, 1, 0);
    run_op("multu", 6'd25, 32'h0001_0000, 32'h0001_0000, 32'd0, 34, 1'b0, 32, 0);
    run_op("mfhi", 6'd16, 32'd0, 32'd0, 32'h0000_0001, 2, 1'b0, 1, 0);
    run_op("mflo", 6'd18, 32'd0, 32'd0, 32'h0000_0000, 2, 1'b0, 1, 0);
    run_op("sub hold", 6'd34, 32'd3, 32'd5, 32'hFFFF_FFFE, 2, 1'b0, 1, 5);
    run_op("slt", 6'd42, 32'hFFFF_FFFF, 32'd1, 32'd1, 2, 1'b0, 1, 0);

    // Reset in the middle of a DIVU, at LONG count 10
    wait_ready("divu", ok);
    if (ok) begin
      watch_fn  = 6'd27;
      req_valid = 1'b1;
      req_funct = 6'd27;
      req_a     = 32'd100;
      req_b     = 32'd7;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (21) @(posedge clk);
      #1;
      check("divu running", {26'd0, alu_signal}, 32'd27);
      check("divu busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      r0 = rsp_cnt;
      check("abort signal", {26'd0, alu_signal}, 32'd0);
      check("abort ready", {31'd0, req_ready}, 32'd1);
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
      repeat (50) @(posedge clk);
      #1;
      check("abort no rsp", 32'(rsp_cnt - r0), 32'd0);
    end

`ifdef ALU_SEQ_ILLEGAL_EN
    run_op("illegal", 6'd63, 32'd1, 32'd2, 32'd0, 1, 1'b1, 0, 0);
`else
    run_op("illegal", 6'd63, 32'd1, 32'd2, 32'hDEAD_003F, 2, 1'b0, 1, 0);
`endif

    run_op("srl", 6'd2, 32'h8000_0000, 32'd4, 32'h0800_0000, 2, 1'b0, 1, 0);
    r0 = last_hs_cyc;
    run_op("or", 6'd37, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 2, 1'b0, 1, 0);
    check("b2b gap ok", {31'd0, (last_acc_cyc - r0) >= 1}, 32'd1);
    run_op("and", 6'd36, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 2, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Request-level sequencer in front of the TotalALU datapath. It accepts one ALU operation at a time over a valid/ready handshake and drives the datapath's `Signal`/`dataA`/`dataB` for exactly the required number of cycles, holding operands stable through multi-cycle MULTU/DIVU. It samples `Output` at the correct cycle and returns a result over a second valid/ready handshake. It gives the datapath a single owner, so upstream logic never times multi-cycle operations itself.

## Interface
Parameters:
- `RES_LAT`, 1: cycles `alu_signal` is held for a single-cycle op before `alu_result` is sampled; range 1–4.
- `MUL_CYCLES`, 32: cycles `alu_signal` is held at MULTU or DIVU.
- `HILO_LAT`, 1: idle cycles after a long op before the completion response; HiLo is settled afterwards.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous reset, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_funct` in 6: funct code (AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, DIVU 27, MFHI 16, MFLO 18).
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_data` out 32: result.
- `rsp_err` out 1: illegal funct (see Configuration).
- `alu_signal` out 6: to datapath `Signal`.
- `alu_a` out 32: to datapath `dataA`.
- `alu_b` out 32: to datapath `dataB`.
- `alu_result` in 32: from datapath `Output`.
- `busy` out 1: high in any state but IDLE.

## Operation
- States: IDLE, SHORT, LONG, SETTLE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid && req_ready`, capture funct/a/b into registers.
  - Go to LONG if funct is MULTU or DIVU, otherwise SHORT.
- **SHORT**
  - Drive `alu_signal`=funct, `alu_a`/`alu_b`=captured operands for RES_LAT cycles.
  - On the last cycle's clock edge, register `alu_result` into `rsp_data`, then go to RESP.
- **LONG**
  - Drive the captured funct and operands for MUL_CYCLES cycles; a 6-bit down-counter loads MUL_CYCLES−1.
  - At count 0, go to SETTLE.
- **SETTLE**
  - Drive `alu_signal`=6'b000000 (datapath NOP) and hold operands for HILO_LAT cycles.
  - Load `rsp_data`=0, then go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_data`/`rsp_err` are stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Outside SHORT and LONG, `alu_signal`=0. `alu_a`/`alu_b` hold their last captured values (no toggling).
- `req_valid` is ignored when `req_ready`=0. Only one operation is in flight at a time.
- MFHI/MFLO are ordinary SHORT ops. Because requests are fully serialized, MFHI/MFLO issued after a MULTU/DIVU completion response always read the settled HiLo.
- No arithmetic is performed in this block; widths pass through unchanged.

## Timing
- Reset (`reset`=0 at a clock edge): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `alu_signal`=0, `alu_a`=0, `alu_b`=0, counter=0, `busy`=0.
- Reset mid-operation aborts immediately and produces no response. HiLo contents are undefined afterwards; upstream must reissue.
- Short op: accept at edge N, `rsp_valid` high from edge N+RES_LAT+1.
- Long op: accept at edge N, `rsp_valid` high from edge N+MUL_CYCLES+HILO_LAT+1.
- `req_ready` is 0 during the cycle the response handshake completes. The earliest next accept is one cycle after the `rsp` handshake.
- `rsp_ready` held low keeps RESP indefinitely. The datapath sees `alu_signal`=0 throughout.
- `req_valid` and `rsp_ready` may both be high in RESP; only the response handshake takes effect.

## Configuration
- `ALU_SEQ_ILLEGAL_EN` defined:
  - A funct outside the ten listed codes is accepted, skips SHORT/LONG, and goes directly to RESP next cycle with `rsp_data`=0 and `rsp_err`=1.
  - `alu_signal` never presents that code.
- `ALU_SEQ_ILLEGAL_EN` undefined:
  - Unknown funct is treated as a SHORT op, passed through to the datapath, and its `alu_result` is returned.
  - `rsp_err` is tied to 0.

## Test plan
- ADD, a=5, b=7, `rsp_ready`=1 → `rsp_valid` at accept+2 (RES_LAT=1), `rsp_data`=12, `rsp_err`=0, `alu_signal`=32 for exactly one cycle.
- MULTU 0x00010000×0x00010000, then MFHI, then MFLO → completion at accept+34 with data 0; MFHI returns 0x00000001, MFLO returns 0x00000000; `alu_signal`=25 for exactly 32 cycles.
- SUB 3−5 with `rsp_ready` low for 5 cycles → `rsp_valid`/`rsp_data`=0xFFFFFFFE held stable all 5 cycles; `req_valid` pulses during this are not accepted.
- DIVU started, `reset`=0 at LONG count 10 → next cycle IDLE, `alu_signal`=0, `req_ready`=1, no `rsp_valid` ever produced.
- Funct 6'b111111 with `ALU_SEQ_ILLEGAL_EN` → `rsp_valid` at accept+1, `rsp_err`=1, `rsp_data`=0, `alu_signal` stays 0. Without the macro → `rsp_err`=0, `alu_signal`=63 for one cycle.
- Back-to-back SRL (a=0x80000000, b=4) then OR → first `rsp_data`=0x08000000; second accept occurs no earlier than one cycle after the first response handshake.
